// File: rtl/traffic_pkg.sv
// Shared constants and types for the traffic display scanner: mode codes,
// slot indices, 7-segment patterns (g..a) and the scan FSM state.
package traffic_pkg;

    localparam logic [1:0] MODE_AUTO   = 2'b00;
    localparam logic [1:0] MODE_POLICE = 2'b01;
    localparam logic [1:0] MODE_TOGGLE = 2'b10;

    localparam logic [1:0] SLOT_A_H = 2'd0;
    localparam logic [1:0] SLOT_A_L = 2'd1;
    localparam logic [1:0] SLOT_B_H = 2'd2;
    localparam logic [1:0] SLOT_B_L = 2'd3;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DARK = 2'd2
    } scan_state_t;

    // Observability bundle: FSM state plus the latched mode and blink phase.
    typedef struct packed {
        scan_state_t state;
        logic [1:0]  mode;
        logic        blink_on;
    } scan_dbg_t;

    function automatic logic mode_blinks(input logic [1:0] m);
        return (m == MODE_POLICE) || (m == MODE_TOGGLE);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to 7-segment (g..a) decoder; 10..15 show a dash.
// Optional: LEADING_ZERO_BLANK_EN blanks a zero in tens-digit positions.
module seg7_decode
    import traffic_pkg::*;
(
    input  logic [3:0] value,
    input  logic       lead_pos,
    output logic [6:0] seg
);

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    always_comb begin
        case (value)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        if (BLANK_EN && lead_pos && (value == 4'd0)) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/traffic_display_scan.sv
// Latches the controller's timer nibbles once per frame and scans them onto a
// 4-digit common-cathode display, blinking in police/toggle mode.
module traffic_display_scan
    import traffic_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 125
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a_ti_h,
    input  logic [3:0] a_ti_l,
    input  logic [3:0] b_ti_h,
    input  logic [3:0] b_ti_l,
    input  logic       a_l,
    input  logic       b_l,
    input  logic [1:0] mode,
    output logic [7:0] seg,
    output logic [3:0] dig_en,
    output logic       frame_start,
    output scan_dbg_t  dbg
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

    scan_state_t      state, state_d;
    logic [DIV_W-1:0] div, div_d;
    logic [1:0]       slot, slot_d;
    logic [FC_W-1:0]  frame_cnt, frame_cnt_d;
    logic             blink_on, blink_on_d;
    logic             capture;

    logic [3:0] sh_a_ti_h, sh_a_ti_l, sh_b_ti_h, sh_b_ti_l;
    logic       sh_a_l, sh_b_l;
    logic [1:0] sh_mode;

    logic [3:0] nibble;
    logic       dp;
    logic       lead_pos;
    logic [6:0] dec_seg;
    logic [7:0] seg_d;
    logic [3:0] dig_en_d;
    logic       frame_start_d;

    always_comb begin
        state_d     = state;
        div_d       = (div == DIV_LAST) ? '0 : div + 1'b1;
        slot_d      = slot;
        frame_cnt_d = frame_cnt;
        blink_on_d  = blink_on;
        capture     = 1'b0;

        if (div == DIV_LAST) begin
            if (state == ST_IDLE) begin
                capture = 1'b1;
            end else begin
                slot_d  = slot + 2'd1;
                capture = (slot == SLOT_B_L);
            end
        end

        // The mode being latched on this edge already governs the new frame.
        if (capture) begin
            if (mode_blinks(mode)) begin
                if (frame_cnt == FC_LAST) begin
                    frame_cnt_d = '0;
                    blink_on_d  = ~blink_on;
                end else begin
                    frame_cnt_d = frame_cnt + 1'b1;
                end
            end else begin
                frame_cnt_d = '0;
                blink_on_d  = 1'b1;
            end
        end

        case (state)
            ST_IDLE: if (capture) state_d = ST_SCAN;
            ST_SCAN: if (capture && !blink_on_d) state_d = ST_DARK;
            ST_DARK: if (capture && blink_on_d) state_d = ST_SCAN;
            default: state_d = ST_IDLE;
        endcase

        dig_en_d      = ((state_d == ST_SCAN) && (div_d != '0)) ? (4'b0001 << slot_d) : 4'b0000;
        frame_start_d = (state_d != ST_IDLE) && (div_d == '0) && (slot_d == SLOT_A_H);
        seg_d         = (state == ST_IDLE) ? 8'h00 : {dp, dec_seg};
    end

    always_comb begin
        nibble = sh_a_ti_h;
        dp     = 1'b0;
        case (slot)
            SLOT_A_H: nibble = sh_a_ti_h;
            SLOT_A_L: begin nibble = sh_a_ti_l; dp = sh_a_l; end
            SLOT_B_H: nibble = sh_b_ti_h;
            default:  begin nibble = sh_b_ti_l; dp = sh_b_l; end
        endcase
    end

    assign lead_pos = (slot == SLOT_A_H) || (slot == SLOT_B_H);

    seg7_decode u_decode (
        .value    (nibble),
        .lead_pos (lead_pos),
        .seg      (dec_seg)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            div       <= '0;
            slot      <= SLOT_A_H;
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            state     <= state_d;
            div       <= div_d;
            slot      <= slot_d;
            frame_cnt <= frame_cnt_d;
            blink_on  <= blink_on_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_a_ti_h <= '0;
            sh_a_ti_l <= '0;
            sh_b_ti_h <= '0;
            sh_b_ti_l <= '0;
            sh_a_l    <= 1'b0;
            sh_b_l    <= 1'b0;
            sh_mode   <= MODE_AUTO;
        end else if (capture) begin
            sh_a_ti_h <= a_ti_h;
            sh_a_ti_l <= a_ti_l;
            sh_b_ti_h <= b_ti_h;
            sh_b_ti_l <= b_ti_l;
            sh_a_l    <= a_l;
            sh_b_l    <= b_l;
            sh_mode   <= mode;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg         <= 8'h00;
            dig_en      <= 4'b0000;
            frame_start <= 1'b0;
        end else begin
            seg         <= seg_d;
            dig_en      <= dig_en_d;
            frame_start <= frame_start_d;
        end
    end

    assign dbg = {state, sh_mode, blink_on};

endmodule
